// File: rtl/tt03_mac_pkg.sv
// Shared widths and helpers for the tt03 FIR/MAC chain and its downstream decimator.
package tt03_mac_pkg;

   localparam int unsigned BW_IN_DEF  = 8;
   localparam int unsigned BW_OUT_DEF = 6;
   localparam int unsigned DECIM_DEF  = 4;
   localparam int unsigned SHIFT_DEF  = 2;

   // Ceiling log2; returns 0 for n <= 1 so a pass-through decimator adds no growth bits.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/round_sat.sv
// Round-half-up arithmetic right shift followed by signed saturation to BW_out bits.
module round_sat #(
   parameter int unsigned ACC_W  = 10,
   parameter int unsigned SHIFT  = 2,
   parameter int unsigned BW_out = 6
) (
   input  logic signed [ACC_W-1:0]  sum,
   output logic signed [BW_out-1:0] value,
   output logic                     sat
);

   // One extra bit so the rounding add cannot wrap.
   localparam int unsigned W = ACC_W + 1;
   localparam logic signed [W-1:0] HALF = W'((64'd1 << SHIFT) >> 1);

   logic signed [W-1:0] ext;
   logic signed [W-1:0] rnd;

   assign ext = {sum[ACC_W-1], sum};
   assign rnd = (ext + HALF) >>> SHIFT;

   generate
      if (BW_out >= W) begin : g_wide
         assign value = BW_out'(rnd);
         assign sat   = 1'b0;
      end else begin : g_clamp
         // In range only when every bit above the output sign bit copies it.
         logic [W-BW_out:0] hi;
         assign hi    = rnd[W-1:BW_out-1];
         assign sat   = !((&hi) || (~|hi));
         assign value = !sat ? rnd[BW_out-1:0]
                      : rnd[W-1] ? {1'b1, {(BW_out-1){1'b0}}}
                                 : {1'b0, {(BW_out-1){1'b1}}};
      end
   endgenerate

endmodule

// File: rtl/fir_decimator.sv
// Integrate-and-dump decimator: sums DECIM accepted FIR words, then rounds, shifts and saturates.
module fir_decimator
   import tt03_mac_pkg::*;
#(
   parameter int unsigned BW_in  = BW_IN_DEF,
   parameter int unsigned BW_out = BW_OUT_DEF,
   parameter int unsigned DECIM  = DECIM_DEF,
   parameter int unsigned SHIFT  = SHIFT_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic signed [BW_in-1:0]  y_in,
   output logic signed [BW_out-1:0] dec_out,
   output logic                     dec_valid,
   output logic                     ovf
);

   localparam int unsigned ACC_W = BW_in + clog2(DECIM);
   localparam int unsigned CNT_W = (DECIM > 1) ? clog2(DECIM) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DECIM - 1);

   logic signed [ACC_W-1:0]  acc;
   logic [CNT_W-1:0]         cnt;
   logic signed [ACC_W-1:0]  sum_c;
   logic signed [BW_out-1:0] value_c;
   logic                     sat_c;

   assign sum_c = acc + ACC_W'(y_in);

   round_sat #(
      .ACC_W (ACC_W),
      .SHIFT (SHIFT),
      .BW_out(BW_out)
   ) u_round_sat (
      .sum  (sum_c),
      .value(value_c),
      .sat  (sat_c)
   );

   // Accumulate accepted samples; the DECIM-th one dumps the rounded block sum.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc       <= '0;
         cnt       <= '0;
         dec_out   <= '0;
         dec_valid <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         dec_valid <= 1'b0;
         if (en) begin
            if (cnt == LAST) begin
               acc       <= '0;
               cnt       <= '0;
               dec_out   <= value_c;
               dec_valid <= 1'b1;
               if (sat_c) ovf <= 1'b1;
            end else begin
               acc <= sum_c;
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule
